alu_ctrl_seq: RTL and testbench
===============================

Name: alu_ctrl_seq

Overview:
- Registered, parametrised successor to the combinational ALU control decoder in the EX stage.
- Decodes ALUOp/Func into the 4-bit ALU select and covers all ALUOp classes (loads/stores, branch, I-type logic/compare, R-type).
- Flags illegal encodings.
- Sequences multi-cycle MUL/DIV: holds the select for a parametrised latency and back-pressures the pipeline with a ready/stall handshake.

Parameters:
- MUL_LAT, 4, cycles MUL occupies the ALU (>=1; 1 means single-cycle).
- DIV_LAT, 32, cycles DIV occupies the ALU (>=1).
- CNT_W, $clog2(max(MUL_LAT,DIV_LAT)+1), latency counter width (derived, not overridden).

Ports:
- clk, input, 1, rising-edge clock.
- rst, input, 1, asynchronous active-high reset.
- valid_in, input, 1, EX-stage instruction present.
- ALUOp, input, 3, main-control ALU class.
- Func, input, 6, R-type funct field.
- flush, input, 1, synchronous abort (branch/exception).
- in_ready, output, 1, block accepts an instruction this cycle.
- sel, output, 4, registered ALU select.
- sel_valid, output, 1, sel carries a live operation.
- busy, output, 1, multi-cycle op in progress.
- done, output, 1, one-cycle pulse on the final cycle of an op.
- illegal, output, 1, registered flag: the accepted encoding was undefined.

Behaviour:
- Reset (async, any state) forces:
  - state IDLE, counter 0, sel=4'b1000 (NOP).
  - sel_valid=0, busy=0, done=0, illegal=0.
- ALUOp decode:
  - 000 ADD 0010.
  - 001 SUB 0110.
  - 011 AND 0000.
  - 100 OR 0001.
  - 101 SLT 0111.
  - 010 R-type by Func.
  - 110/111 illegal.
- R-type Func decode:
  - 100000 ADD 0010.
  - 100100 AND 0000.
  - 100101 OR 0001.
  - 100010 SUB 0110.
  - 101010 SLT 0111.
  - 000000 NOP 1000.
  - 000010 MUL 0011.
  - 011010 DIV 0100.
  - Any other Func is illegal.
- Illegal encoding: sel=1000, illegal=1, sel_valid=1, done=1 for one cycle. The output never holds a stale value.
- Handshake:
  - in_ready = (state==IDLE) | done.
  - An instruction is accepted on a cycle with valid_in & in_ready & ~flush.
  - While in_ready=0, upstream holds valid_in/ALUOp/Func. The inputs are ignored in that state.
- Latency: accept in cycle N -> sel/sel_valid valid from N+1.
- Single-cycle op:
  - sel_valid=1 and done=1 in N+1 only, busy=0.
  - Back-to-back accepts give continuous sel_valid.
- Multi-cycle op (MUL, lat L = MUL_LAT; DIV, L = DIV_LAT; L>1):
  - state BUSY.
  - sel held constant N+1..N+L.
  - busy=1 N+1..N+L.
  - done=1 at N+L only.
  - Counter loads L-1 on accept and decrements each cycle. done fires when the counter is 0.
  - A new instruction may be accepted at N+L (in_ready via done), giving zero-bubble issue.
  - MUL/DIV with L==1 behaves as a single-cycle op.
- FSM:
  - IDLE -> BUSY on accept of a multi-cycle op. Other accepts stay in IDLE.
  - BUSY -> IDLE when the counter reaches 0 with no new accept.
  - BUSY -> BUSY when the counter reaches 0 and a multi-cycle op is accepted at the same time (reload).
- flush:
  - Priority over valid_in.
  - Next cycle: state IDLE, counter 0, sel=1000, sel_valid/busy/done/illegal=0.
  - No done pulse for an aborted op.
- No accept, no flush: sel returns to 1000 and sel_valid=0 after a single-cycle op completes.

Decomposition:
- Package alu_ctrl_pkg:
  - sel code localparams (SEL_AND..SEL_NOP).
  - ALUOp class codes.
  - Funct codes.
  - is_multicycle function.
- Sub-module alu_ctrl_decode (pure combinational): ALUOp/Func -> {sel, illegal, multicycle}.
- alu_ctrl_seq holds the FSM, counter, and output registers.

Test Plan:
- Reset mid-DIV (cycle 5 of 32) -> same-cycle sel=1000, busy=0, done=0, in_ready=1; no done pulse afterwards.
- ALUOp=010, Func=100000, then 100010, then 101010 on consecutive cycles -> sel 0010, 0110, 0111 in N+1..N+3, sel_valid and done high each cycle, busy=0.
- MUL accepted at N, MUL_LAT=4 -> sel=0011 and busy=1 for N+1..N+4, in_ready=0 for N+1..N+3, done only at N+4. DIV offered at N+4 is accepted: sel=0100 from N+5, done at N+36 (DIV_LAT=32).
- Func=111111 with ALUOp=010, then ALUOp=111 -> each gives sel=1000, illegal=1, done=1 for one cycle, state stays IDLE.
- Flush at N+2 of a MUL with valid_in=1 -> N+3: all outputs at reset values, the offered instruction is not accepted, in_ready=1.
- ALUOp 000/001/011/100/101 with arbitrary Func -> sel 0010/0110/0000/0001/0111, illegal=0.

Source files
------------

// File: rtl/alu_ctrl_pkg.sv
// rtl/alu_ctrl_pkg.sv - shared encodings for the ALU control sequencer
package alu_ctrl_pkg;

    // ALU select codes driven to the datapath
    localparam logic [3:0] SEL_AND = 4'b0000;
    localparam logic [3:0] SEL_OR  = 4'b0001;
    localparam logic [3:0] SEL_ADD = 4'b0010;
    localparam logic [3:0] SEL_MUL = 4'b0011;
    localparam logic [3:0] SEL_DIV = 4'b0100;
    localparam logic [3:0] SEL_SUB = 4'b0110;
    localparam logic [3:0] SEL_SLT = 4'b0111;
    localparam logic [3:0] SEL_NOP = 4'b1000;

    // Main-control ALU classes
    localparam logic [2:0] ALUOP_ADD   = 3'b000;
    localparam logic [2:0] ALUOP_SUB   = 3'b001;
    localparam logic [2:0] ALUOP_RTYPE = 3'b010;
    localparam logic [2:0] ALUOP_AND   = 3'b011;
    localparam logic [2:0] ALUOP_OR    = 3'b100;
    localparam logic [2:0] ALUOP_SLT   = 3'b101;

    // R-type funct field codes
    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_SLT = 6'b101010;
    localparam logic [5:0] FUNCT_NOP = 6'b000000;
    localparam logic [5:0] FUNCT_MUL = 6'b000010;
    localparam logic [5:0] FUNCT_DIV = 6'b011010;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    // Only MUL and DIV can occupy the ALU for more than one cycle
    function automatic logic is_multicycle(input logic [3:0] s);
        return (s == SEL_MUL) || (s == SEL_DIV);
    endfunction

endpackage

// File: rtl/alu_ctrl_decode.sv
// rtl/alu_ctrl_decode.sv - combinational ALUOp/Func to ALU select decoder
module alu_ctrl_decode
    import alu_ctrl_pkg::*;
(
    input  logic [2:0] ALUOp,
    input  logic [5:0] Func,
    output logic [3:0] sel,
    output logic       illegal,
    output logic       multicycle
);

    // Class decode first; R-type falls through to the funct table.
    // Undefined encodings select NOP so nothing stale reaches the ALU.
    always_comb begin
        sel     = SEL_NOP;
        illegal = 1'b0;
        case (ALUOp)
            ALUOP_ADD: sel = SEL_ADD;
            ALUOP_SUB: sel = SEL_SUB;
            ALUOP_AND: sel = SEL_AND;
            ALUOP_OR:  sel = SEL_OR;
            ALUOP_SLT: sel = SEL_SLT;
            ALUOP_RTYPE: begin
                case (Func)
                    FUNCT_ADD: sel = SEL_ADD;
                    FUNCT_AND: sel = SEL_AND;
                    FUNCT_OR:  sel = SEL_OR;
                    FUNCT_SUB: sel = SEL_SUB;
                    FUNCT_SLT: sel = SEL_SLT;
                    FUNCT_NOP: sel = SEL_NOP;
                    FUNCT_MUL: sel = SEL_MUL;
                    FUNCT_DIV: sel = SEL_DIV;
                    default:   illegal = 1'b1;
                endcase
            end
            default: illegal = 1'b1;
        endcase
    end

    assign multicycle = is_multicycle(sel);

endmodule

// File: rtl/alu_ctrl_seq.sv
// rtl/alu_ctrl_seq.sv - registered ALU control with multi-cycle MUL/DIV sequencing
module alu_ctrl_seq
    import alu_ctrl_pkg::*;
#(
    parameter int MUL_LAT = 4,
    parameter int DIV_LAT = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       valid_in,
    input  logic [2:0] ALUOp,
    input  logic [5:0] Func,
    input  logic       flush,
    output logic       in_ready,
    output logic [3:0] sel,
    output logic       sel_valid,
    output logic       busy,
    output logic       done,
    output logic       illegal
);

    localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int CNT_W   = $clog2(MAX_LAT + 1);

    // Counter load values: remaining cycles after the first one
    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_LAT - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_LAT - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       sel_q, sel_d;
    logic             sel_valid_q, sel_valid_d;
    logic             illegal_q, illegal_d;

    logic [3:0]       dec_sel;
    logic             dec_illegal;
    logic             dec_multi;
    logic [CNT_W-1:0] op_load;
    logic             goes_busy;
    logic             accept;

    alu_ctrl_decode u_decode (
        .ALUOp      (ALUOp),
        .Func       (Func),
        .sel        (dec_sel),
        .illegal    (dec_illegal),
        .multicycle (dec_multi)
    );

    // A live op finishes on the cycle its counter has run out; single-cycle
    // ops are loaded with zero so they finish on their only cycle.
    assign done     = sel_valid_q & (cnt_q == '0);
    assign busy     = (state_q == ST_BUSY);
    assign in_ready = (state_q == ST_IDLE) | done;
    assign accept   = valid_in & in_ready & ~flush;

    // A latency of one collapses MUL/DIV into an ordinary single-cycle op
    assign op_load   = (dec_sel == SEL_DIV) ? DIV_LOAD : MUL_LOAD;
    assign goes_busy = dec_multi & (op_load != '0);

    // State, counter and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            sel_q       <= SEL_NOP;
            sel_valid_q <= 1'b0;
            illegal_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sel_q       <= sel_d;
            sel_valid_q <= sel_valid_d;
            illegal_q   <= illegal_d;
        end
    end

    // Next state: flush beats accept, accept beats countdown, otherwise drain to NOP
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        sel_d       = sel_q;
        sel_valid_d = sel_valid_q;
        illegal_d   = illegal_q;
        if (flush) begin
            state_d     = ST_IDLE;
            cnt_d       = '0;
            sel_d       = SEL_NOP;
            sel_valid_d = 1'b0;
            illegal_d   = 1'b0;
        end else if (accept) begin
            sel_d       = dec_sel;
            sel_valid_d = 1'b1;
            illegal_d   = dec_illegal;
            if (goes_busy) begin
                state_d = ST_BUSY;
                cnt_d   = op_load;
            end else begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        end else if ((state_q == ST_BUSY) && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_W'(1);
        end else begin
            state_d     = ST_IDLE;
            cnt_d       = '0;
            sel_d       = SEL_NOP;
            sel_valid_d = 1'b0;
            illegal_d   = 1'b0;
        end
    end

    assign sel       = sel_q;
    assign sel_valid = sel_valid_q;
    assign illegal   = illegal_q;

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// tb/tb_alu_ctrl_seq.sv - self-checking bench for alu_ctrl_seq
module tb_alu_ctrl_seq;

    localparam int MUL_LAT = 4;
    localparam int DIV_LAT = 32;

    localparam logic [3:0] S_AND = 4'b0000;
    localparam logic [3:0] S_OR  = 4'b0001;
    localparam logic [3:0] S_ADD = 4'b0010;
    localparam logic [3:0] S_MUL = 4'b0011;
    localparam logic [3:0] S_DIV = 4'b0100;
    localparam logic [3:0] S_SUB = 4'b0110;
    localparam logic [3:0] S_SLT = 4'b0111;
    localparam logic [3:0] S_NOP = 4'b1000;

    logic       clk = 1'b0;
    logic       rst;
    logic       valid_in;
    logic [2:0] ALUOp;
    logic [5:0] Func;
    logic       flush;
    logic       in_ready;
    logic [3:0] sel;
    logic       sel_valid;
    logic       busy;
    logic       done;
    logic       illegal;

    int total = 0;
    int bad   = 0;

    // Reference model: the op currently on the outputs and how many cycles it has left
    logic       m_live;
    logic [3:0] m_sel;
    logic       m_ill;
    int         m_len;
    int         m_rem;

    typedef struct packed {
        logic [2:0] op;
        logic [5:0] fn;
        logic [3:0] sel;
        logic       ill;
    } vec_t;

    vec_t tbl[14];
    logic [5:0] funcs[8];

    alu_ctrl_seq #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
        .clk       (clk),
        .rst       (rst),
        .valid_in  (valid_in),
        .ALUOp     (ALUOp),
        .Func      (Func),
        .flush     (flush),
        .in_ready  (in_ready),
        .sel       (sel),
        .sel_valid (sel_valid),
        .busy      (busy),
        .done      (done),
        .illegal   (illegal)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

    task automatic ref_decode(input logic [2:0] op, input logic [5:0] fn,
                              output logic [3:0] s, output logic il);
        s  = S_NOP;
        il = 1'b0;
        case (op)
            3'd0: s = S_ADD;
            3'd1: s = S_SUB;
            3'd3: s = S_AND;
            3'd4: s = S_OR;
            3'd5: s = S_SLT;
            3'd2: begin
                case (fn)
                    6'b100000: s = S_ADD;
                    6'b100100: s = S_AND;
                    6'b100101: s = S_OR;
                    6'b100010: s = S_SUB;
                    6'b101010: s = S_SLT;
                    6'b000000: s = S_NOP;
                    6'b000010: s = S_MUL;
                    6'b011010: s = S_DIV;
                    default:   il = 1'b1;
                endcase
            end
            default: il = 1'b1;
        endcase
    endtask

    task automatic model_reset();
        m_live = 1'b0;
        m_sel  = S_NOP;
        m_ill  = 1'b0;
        m_len  = 0;
        m_rem  = 0;
    endtask

    task automatic model_clock(input logic v, input logic [2:0] op,
                               input logic [5:0] fn, input logic fl);
        logic       rdy;
        logic [3:0] s;
        logic       il;
        rdy = !m_live || (m_rem == 1);
        if (fl) begin
            model_reset();
        end else if (v && rdy) begin
            ref_decode(op, fn, s, il);
            m_live = 1'b1;
            m_sel  = s;
            m_ill  = il;
            m_len  = (s == S_MUL) ? MUL_LAT : (s == S_DIV) ? DIV_LAT : 1;
            m_rem  = m_len;
        end else if (m_live) begin
            m_rem = m_rem - 1;
            if (m_rem == 0) model_reset();
        end
    endtask

    function automatic logic [8:0] model_out();
        logic live_end;
        live_end = m_live && (m_rem == 1);
        return {(!m_live || live_end), (m_live ? m_sel : S_NOP), m_live,
                (m_live && m_len > 1), live_end, (m_live && m_ill)};
    endfunction

    task automatic check_model(input string name);
        logic [8:0] act;
        logic [8:0] exp;
        act = {in_ready, sel, sel_valid, busy, done, illegal};
        exp = model_out();
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got rdy/sel/sv/busy/done/ill=%b want %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_val(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs, check outputs at the falling edge, advance model on the rising edge
    task automatic tick(input logic v, input logic [2:0] op, input logic [5:0] fn,
                        input logic fl, input string name);
        valid_in = v;
        ALUOp    = op;
        Func     = fn;
        flush    = fl;
        @(negedge clk);
        check_model(name);
        @(posedge clk);
        model_clock(v, op, fn, fl);
        #1;
    endtask

    // Counts cycles (1 = current) until done, ticking with the given inputs meanwhile
    task automatic count_to_done(input string name, input int exp, input logic v,
                                 input logic [2:0] op, input logic [5:0] fn);
        int k;
        k = -1;
        for (int i = 1; i <= exp + 8; i++) begin
            if (done === 1'b1) begin
                k = i;
                break;
            end
            tick(v, op, fn, 1'b0, name);
        end
        check_val(name, k, exp);
    endtask

    initial begin
        rst      = 1'b1;
        valid_in = 1'b0;
        ALUOp    = 3'd0;
        Func     = 6'd0;
        flush    = 1'b0;
        model_reset();

        tbl[0]  = '{3'b010, 6'b100000, S_ADD, 1'b0};
        tbl[1]  = '{3'b010, 6'b100010, S_SUB, 1'b0};
        tbl[2]  = '{3'b010, 6'b101010, S_SLT, 1'b0};
        tbl[3]  = '{3'b010, 6'b100100, S_AND, 1'b0};
        tbl[4]  = '{3'b010, 6'b100101, S_OR,  1'b0};
        tbl[5]  = '{3'b010, 6'b000000, S_NOP, 1'b0};
        tbl[6]  = '{3'b010, 6'b111111, S_NOP, 1'b1};
        tbl[7]  = '{3'b111, 6'b100000, S_NOP, 1'b1};
        tbl[8]  = '{3'b110, 6'b000010, S_NOP, 1'b1};
        tbl[9]  = '{3'b000, 6'b000010, S_ADD, 1'b0};
        tbl[10] = '{3'b001, 6'b011010, S_SUB, 1'b0};
        tbl[11] = '{3'b011, 6'b111111, S_AND, 1'b0};
        tbl[12] = '{3'b100, 6'b100010, S_OR,  1'b0};
        tbl[13] = '{3'b101, 6'b010101, S_SLT, 1'b0};

        funcs[0] = 6'b100000; funcs[1] = 6'b100100; funcs[2] = 6'b100101;
        funcs[3] = 6'b100010; funcs[4] = 6'b101010; funcs[5] = 6'b000000;
        funcs[6] = 6'b000010; funcs[7] = 6'b011010;

        // Reset state
        @(negedge clk);
        check_model("reset_state");
        @(posedge clk);
        #1;
        rst = 1'b0;
        tick(1'b0, 3'd0, 6'd0, 1'b0, "idle");

        // Back-to-back decode table: each accept is live and done on the very next cycle
        for (int i = 0; i < 14; i++) begin
            tick(1'b1, tbl[i].op, tbl[i].fn, 1'b0, "table_model");
            check_val($sformatf("table%0d_sel", i), int'(sel), int'(tbl[i].sel));
            check_val($sformatf("table%0d_flags", i), int'({illegal, sel_valid, done, busy}),
                      int'({tbl[i].ill, 3'b110}));
        end
        tick(1'b0, 3'd0, 6'd0, 1'b0, "drain");
        check_val("drain_sel", int'({sel, sel_valid}), int'({S_NOP, 1'b0}));

        // MUL then DIV offered and held; DIV issues with no bubble when MUL completes
        tick(1'b1, 3'b010, 6'b000010, 1'b0, "mul_accept");
        check_val("mul_sel_busy", int'({sel, busy, in_ready}), int'({S_MUL, 1'b1, 1'b0}));
        count_to_done("mul_latency", MUL_LAT, 1'b1, 3'b010, 6'b011010);
        tick(1'b1, 3'b010, 6'b011010, 1'b0, "div_accept");
        check_val("div_sel_busy", int'({sel, busy}), int'({S_DIV, 1'b1}));
        count_to_done("div_latency", DIV_LAT, 1'b0, 3'd0, 6'd0);
        tick(1'b0, 3'd0, 6'd0, 1'b0, "div_drain");
        check_val("div_drain", int'({sel, sel_valid, busy, done}), int'({S_NOP, 3'b000}));

        // Flush during cycle N+2 of a MUL while a new instruction is offered
        tick(1'b1, 3'b010, 6'b000010, 1'b0, "flush_mul_accept");
        tick(1'b0, 3'd0, 6'd0, 1'b0, "flush_n1");
        tick(1'b1, 3'b000, 6'd0, 1'b1, "flush_n2");
        check_val("flush_outputs", int'({in_ready, sel, sel_valid, busy, done, illegal}),
                  int'({1'b1, S_NOP, 4'b0000}));
        for (int i = 0; i < 6; i++) tick(1'b0, 3'd0, 6'd0, 1'b0, "post_flush");

        // Asynchronous reset during cycle 5 of a DIV
        tick(1'b1, 3'b010, 6'b011010, 1'b0, "rst_div_accept");
        for (int i = 0; i < 4; i++) tick(1'b0, 3'd0, 6'd0, 1'b0, "rst_div_run");
        #2;
        rst = 1'b1;
        #1;
        check_val("async_reset", int'({sel, busy, done, in_ready, sel_valid}),
                  int'({S_NOP, 4'b0010}));
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < DIV_LAT + 4; i++) tick(1'b0, 3'd0, 6'd0, 1'b0, "post_reset_quiet");

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            logic       v;
            logic [2:0] op;
            logic [5:0] fn;
            logic       fl;
            v  = ($urandom_range(0, 9) < 7);
            op = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 9) < 2) op = 3'b010;
            fn = ($urandom_range(0, 9) < 8) ? funcs[$urandom_range(0, 7)] : 6'($urandom);
            fl = ($urandom_range(0, 99) < 4);
            tick(v, op, fn, fl, "random");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
